zion_bit_write_arbiter: RTL and testbench

//   Shares one field-write path into a WIDTH_DATA_OUT-bit register between NUM_REQ requesters.

---
 rtl/zion_bit_write_arbiter.sv | 126 ++++++++++++
 tb/tb_zion_bit_write_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/zion_bit_write_arbiter.sv
// rtl/zion_bit_write_arbiter.sv - round-robin arbitrated field writes into a held register (ZION_BIT_WRITE_ARB_PRIO_EN selects fixed priority)
module zion_bit_write_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int WIDTH_ADDR     = 2,
    parameter int WIDTH_DATA_IN  = 4,
    parameter int WIDTH_DATA_OUT = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              iHold,
    input  logic [NUM_REQ-1:0]                iReqVld,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0]     iReqAddr,
    input  logic [NUM_REQ*WIDTH_DATA_IN-1:0]  iReqDat,
    output logic [NUM_REQ-1:0]                oReqRdy,
    output logic [WIDTH_DATA_OUT-1:0]         oDat,
    output logic                              oUpdVld,
    output logic [WIDTH_ADDR-1:0]             oUpdAddr,
    output logic                              oErr
);

    localparam int NUM_FIELDS = WIDTH_DATA_OUT / WIDTH_DATA_IN;
    localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Parameter sanity: register must split evenly into addressable fields.
    if ((NUM_REQ < 2) ||
        ((WIDTH_DATA_OUT % WIDTH_DATA_IN) != 0) ||
        (WIDTH_DATA_OUT > (2**WIDTH_ADDR) * WIDTH_DATA_IN)) begin : g_param_err
        $error("zion_bit_write_arbiter: illegal parameter combination");
    end

    logic [PTR_W-1:0]          w_ptr;
    logic [NUM_REQ-1:0]        w_gnt;
    logic                      w_gnt_vld;
    logic [PTR_W-1:0]          w_gnt_idx;
    logic [WIDTH_ADDR-1:0]     w_sel_addr;
    logic [WIDTH_DATA_IN-1:0]  w_sel_dat;
    logic                      w_addr_ok;

    logic [WIDTH_DATA_OUT-1:0] r_dat;
    logic                      r_upd_vld;
    logic [WIDTH_ADDR-1:0]     r_upd_addr;
    logic                      r_err;

`ifdef ZION_BIT_WRITE_ARB_PRIO_EN
    // Fixed priority: the search always starts at requester 0.
    assign w_ptr = '0;
`else
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;

    assign w_ptr_nxt = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Round-robin pointer moves just past the last granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign w_ptr = r_ptr;
`endif

    // Find the first valid requester at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (!rst && !iHold) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                idx = (int'(w_ptr) + off) % NUM_REQ;
                if (!w_gnt_vld && iReqVld[idx]) begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_idx  = PTR_W'(idx);
                    w_gnt[idx] = 1'b1;
                end
            end
        end
    end

    assign oReqRdy = w_gnt;

    // Route the granted requester's field index and data to the merge path.
    always_comb begin
        w_sel_addr = '0;
        w_sel_dat  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = iReqAddr[i*WIDTH_ADDR +: WIDTH_ADDR];
                w_sel_dat  = iReqDat[i*WIDTH_DATA_IN +: WIDTH_DATA_IN];
            end
        end
    end

    assign w_addr_ok = (int'(w_sel_addr) < NUM_FIELDS);

    // Merge the accepted field into the held register; bad addresses only raise oErr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dat      <= '1;
            r_upd_vld  <= 1'b0;
            r_upd_addr <= '0;
            r_err      <= 1'b0;
        end else begin
            r_upd_vld <= w_gnt_vld && w_addr_ok;
            r_err     <= w_gnt_vld && !w_addr_ok;
            if (w_gnt_vld && w_addr_ok) begin
                r_upd_addr <= w_sel_addr;
                for (int f = 0; f < NUM_FIELDS; f++) begin
                    if (w_sel_addr == WIDTH_ADDR'(f)) begin
                        r_dat[f*WIDTH_DATA_IN +: WIDTH_DATA_IN] <= w_sel_dat;
                    end
                end
            end
        end
    end

    assign oDat     = r_dat;
    assign oUpdVld  = r_upd_vld;
    assign oUpdAddr = r_upd_addr;
    assign oErr     = r_err;

endmodule

// File: tb/tb_zion_bit_write_arbiter.sv
// tb/tb_zion_bit_write_arbiter.sv - directed self-checking bench for zion_bit_write_arbiter
module tb_zion_bit_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iHold;
    logic [2:0]  iReqVld;
    logic [5:0]  iReqAddr;
    logic [11:0] iReqDat;
    logic [2:0]  oReqRdy;
    logic [11:0] oDat;
    logic        oUpdVld;
    logic [1:0]  oUpdAddr;
    logic        oErr;

    int errors = 0;
    int checks = 0;

    zion_bit_write_arbiter #(
        .NUM_REQ(3), .WIDTH_ADDR(2), .WIDTH_DATA_IN(4), .WIDTH_DATA_OUT(12)
    ) dut (
        .clk(clk), .rst(rst), .iHold(iHold),
        .iReqVld(iReqVld), .iReqAddr(iReqAddr), .iReqDat(iReqDat),
        .oReqRdy(oReqRdy), .oDat(oDat), .oUpdVld(oUpdVld),
        .oUpdAddr(oUpdAddr), .oErr(oErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; iHold = 1'b0; iReqVld = 3'b111; iReqAddr = '0; iReqDat = '0;
        #1;
        chk("rdy_in_reset", oReqRdy, 3'b000);
        tick(); tick();

        // 1. idle after reset
        rst = 1'b0; iReqVld = 3'b000; #1;
        chk("rst_dat", oDat, 12'hFFF);
        chk("rst_rdy", oReqRdy, 3'b000);
        chk("rst_upd", oUpdVld, 1'b0);
        chk("rst_err", oErr, 1'b0);
        chk("rst_addr", oUpdAddr, 2'd0);

        // 2. single request from req1 to field 1
        iReqVld = 3'b010; iReqAddr = 6'b00_01_00; iReqDat = 12'h0A0; #1;
        chk("t2_rdy", oReqRdy, 3'b010);
        tick();
        iReqVld = 3'b000; #1;
        chk("t2_dat", oDat, 12'hFAF);
        chk("t2_upd", oUpdVld, 1'b1);
        chk("t2_addr", oUpdAddr, 2'd1);

        // re-reset so the pointer is back at 0
        rst = 1'b1; tick(); rst = 1'b0; #1;

        // 3. all three valid, each to its own field
        iReqVld = 3'b111; iReqAddr = 6'b10_01_00; iReqDat = 12'h321; #1;
        chk("t3_rdy0", oReqRdy, 3'b001);
        tick();
        chk("t3_dat0", oDat, 12'hFF1);
        chk("t3_addr0", oUpdAddr, 2'd0);
        chk("t3_rdy1", oReqRdy, 3'b010);
        tick();
        chk("t3_dat1", oDat, 12'hF21);
        chk("t3_addr1", oUpdAddr, 2'd1);
        chk("t3_rdy2", oReqRdy, 3'b100);
        tick();
        iReqVld = 3'b000; #1;
        chk("t3_dat2", oDat, 12'h321);
        chk("t3_addr2", oUpdAddr, 2'd2);
        chk("t3_upd2", oUpdVld, 1'b1);
        tick();
        chk("idle_upd", oUpdVld, 1'b0);
        chk("idle_dat", oDat, 12'h321);
        chk("idle_addr", oUpdAddr, 2'd2);

        // 4. out-of-range field address from req0
        iReqVld = 3'b001; iReqAddr = 6'b00_00_11; iReqDat = 12'h005; #1;
        chk("t4_rdy", oReqRdy, 3'b001);
        tick();
        iReqVld = 3'b000; #1;
        chk("t4_err", oErr, 1'b1);
        chk("t4_upd", oUpdVld, 1'b0);
        chk("t4_dat", oDat, 12'h321);
        tick();
        chk("t4_err_clr", oErr, 1'b0);

        // 5. hold blocks grants; release resumes at pointer 1
        iHold = 1'b1; iReqVld = 3'b111; iReqAddr = 6'b10_01_00; iReqDat = 12'h654; #1;
        chk("t5_rdy_hold", oReqRdy, 3'b000);
        tick();
        chk("t5_dat_hold", oDat, 12'h321);
        chk("t5_upd_hold", oUpdVld, 1'b0);
        iHold = 1'b0; #1;
        chk("t5_rdy_rel", oReqRdy, 3'b010);
        tick();
        iReqVld = 3'b000; #1;
        chk("t5_dat_rel", oDat, 12'h351);
        chk("t5_addr_rel", oUpdAddr, 2'd1);

        // 6. reset coincident with a request (pointer was 2)
        rst = 1'b1; iReqVld = 3'b100; iReqAddr = 6'b10_00_00; iReqDat = 12'h700; #1;
        chk("t6_rdy_rst", oReqRdy, 3'b000);
        tick();
        rst = 1'b0; iReqVld = 3'b000; #1;
        chk("t6_dat", oDat, 12'hFFF);
        chk("t6_upd", oUpdVld, 1'b0);
        iReqVld = 3'b111; #1;
        chk("t6_ptr0", oReqRdy, 3'b001);
        iReqVld = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
